// File: rtl/lyr2_seq_if.sv
// Bundle of stream, coefficient-config and MAC-operand signals for lyr2_seq.
// slave = the sequencer, master = the surrounding logic (source, config, MAC, sink).
interface lyr2_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic [15:0] mac_d1;
    logic [15:0] mac_d2;
    logic [15:0] mac_w1;
    logic [15:0] mac_w2;
    logic [15:0] mac_b;
    logic [15:0] mac_res;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_idx;

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, mac_res, out_ready,
        output in_ready, cfg_ready, mac_d1, mac_d2, mac_w1, mac_w2, mac_b,
               out_valid, out_data, out_idx
    );

    modport master (
        output in_valid, in_data, cfg_we, cfg_addr, cfg_data, mac_res, out_ready,
        input  in_ready, cfg_ready, mac_d1, mac_d2, mac_w1, mac_w2, mac_b,
               out_valid, out_data, out_idx
    );
endinterface

// File: rtl/lyr2_seq.sv
// Layer-2 sequencer: latches an activation pair, walks N_OUT neurons through the
// external MAC one per result handshake, and emits ReLU-optional Q8.8 results.
module lyr2_seq #(
    parameter int N_OUT   = 4,
    parameter int RELU_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    lyr2_seq_if.slave   bus
);
    typedef enum logic [1:0] {S_X1, S_X2, S_MAC, S_OUT} state_t;

    localparam logic [4:0] N_COEF   = 5'(3 * N_OUT);
    localparam logic [2:0] LAST_IDX = 3'(N_OUT - 1);

    state_t      state_r;
    logic [2:0]  idx_r;
    logic [15:0] x1_r;
    logic [15:0] x2_r;
    logic [15:0] coef_r [0:15];
    logic        out_valid_r;
    logic [15:0] out_data_r;
    logic [2:0]  out_idx_r;
    logic [3:0]  base_s;

    function automatic logic [15:0] act_f(input logic [15:0] r);
        if ((RELU_EN != 0) && r[15]) begin
            return 16'h0000;
        end else begin
            return r;
        end
    endfunction

    // idx < N_OUT always holds, so base_s+2 stays inside the written coefficient range
    assign base_s        = {1'b0, idx_r} * 4'd3;
    assign bus.mac_w1    = coef_r[base_s];
    assign bus.mac_w2    = coef_r[base_s + 4'd1];
    assign bus.mac_b     = coef_r[base_s + 4'd2];
    assign bus.mac_d1    = x1_r;
    assign bus.mac_d2    = x2_r;
    assign bus.in_ready  = (state_r == S_X1) || (state_r == S_X2);
    assign bus.cfg_ready = (state_r == S_X1);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;

    // Sequencer FSM with operand, coefficient and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_X1;
            idx_r       <= 3'd0;
            x1_r        <= 16'h0000;
            x2_r        <= 16'h0000;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_idx_r   <= 3'd0;
            for (int i = 0; i < 16; i++) begin
                coef_r[i] <= 16'h0000;
            end
        end else begin
            case (state_r)
                S_X1: begin
                    if (bus.cfg_we && ({1'b0, bus.cfg_addr} < N_COEF)) begin
                        coef_r[bus.cfg_addr] <= bus.cfg_data;
                    end
                    if (bus.in_valid) begin
                        x1_r    <= bus.in_data;
                        state_r <= S_X2;
                    end
                end
                S_X2: begin
                    if (bus.in_valid) begin
                        x2_r    <= bus.in_data;
                        idx_r   <= 3'd0;
                        state_r <= S_MAC;
                    end
                end
                S_MAC: begin
                    out_data_r  <= act_f(bus.mac_res);
                    out_idx_r   <= idx_r;
                    out_valid_r <= 1'b1;
                    state_r     <= S_OUT;
                end
                S_OUT: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            idx_r   <= 3'd0;
                            state_r <= S_X1;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            state_r <= S_MAC;
                        end
                    end
                end
                default: begin
                    state_r     <= S_X1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lyr2_seq.sv
// Scoreboard bench: drives a ReLU and a pass-through instance with identical stimulus
// and compares each emitted result against hand-computed expectations.
module tb_lyr2_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [15:0] cfg_data = 16'h0000;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [18:0] q_a[$];
    logic [18:0] q_b[$];
    logic        held_v [2];
    logic [18:0] held   [2];

    lyr2_seq_if bus_a ();
    lyr2_seq_if bus_b ();

    lyr2_seq #(.N_OUT(4), .RELU_EN(1)) u_relu (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    lyr2_seq #(.N_OUT(4), .RELU_EN(0)) u_pass (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    always #5 clk = ~clk;

    function automatic logic [15:0] mac_f(input logic [15:0] d1, d2, w1, w2, b);
        logic signed [31:0] a1, a2, c1, c2, acc;
        a1 = {{16{d1[15]}}, d1};
        a2 = {{16{d2[15]}}, d2};
        c1 = {{16{w1[15]}}, w1};
        c2 = {{16{w2[15]}}, w2};
        acc = (a1 * c1 + a2 * c2) >>> 8;
        return acc[15:0] + b;
    endfunction

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.cfg_we    = cfg_we;
    assign bus_a.cfg_addr  = cfg_addr;
    assign bus_a.cfg_data  = cfg_data;
    assign bus_a.out_ready = out_ready;
    assign bus_a.mac_res   = mac_f(bus_a.mac_d1, bus_a.mac_d2, bus_a.mac_w1, bus_a.mac_w2, bus_a.mac_b);
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.cfg_we    = cfg_we;
    assign bus_b.cfg_addr  = cfg_addr;
    assign bus_b.cfg_data  = cfg_data;
    assign bus_b.out_ready = out_ready;
    assign bus_b.mac_res   = mac_f(bus_b.mac_d1, bus_b.mac_d2, bus_b.mac_w1, bus_b.mac_w2, bus_b.mac_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int k, input logic v, input logic r, input logic [18:0] got);
        logic [18:0] exp;
        if (held_v[k] && v) check(k == 0 ? "stall_hold_relu" : "stall_hold_pass", 32'(got), 32'(held[k]));
        if (v && r) begin
            if ((k == 0 ? q_a.size() : q_b.size()) == 0) begin
                check(k == 0 ? "unexpected_relu" : "unexpected_pass", 32'(got), 32'h7fff_ffff);
            end else begin
                exp = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                check(k == 0 ? "result_relu" : "result_pass", 32'(got), 32'(exp));
            end
        end
        held_v[k] = v && !r;
        held[k]   = got;
    endtask

    // Monitor: samples both instances on the falling edge, away from the active edge
    always @(negedge clk) begin
        mon_step(0, bus_a.out_valid, out_ready, {bus_a.out_idx, bus_a.out_data});
        mon_step(1, bus_b.out_valid, out_ready, {bus_b.out_idx, bus_b.out_data});
    end

    task automatic wait_idle();
        for (int n = 0; n < 100 && !bus_a.cfg_ready; n++) begin
            @(posedge clk); #1;
        end
        check("idle_wait", 32'(bus_a.cfg_ready), 32'd1);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_beats(input logic [15:0] x1, input logic [15:0] x2);
        in_valid = 1'b1; in_data = x1;
        @(posedge clk); #1;
        in_data = x2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_mac_cycle", 32'(bus_a.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_first_out", 32'(bus_a.out_valid), 32'd1);
    endtask

    // ea/eb pack the four expected results, neuron 0 in the top 16 bits
    task automatic send_pair(input logic [15:0] x1, input logic [15:0] x2,
                             input logic [63:0] ea, input logic [63:0] eb);
        for (int j = 0; j < 4; j++) begin
            q_a.push_back({3'(j), ea[63 - 16 * j -: 16]});
            q_b.push_back({3'(j), eb[63 - 16 * j -: 16]});
        end
        send_beats(x1, x2);
    endtask

    initial begin
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        held[0] = 19'd0;  held[1] = 19'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("rst_cfg_ready", 32'(bus_a.cfg_ready), 32'd1);
        check("rst_w1", 32'(bus_a.mac_w1), 32'd0);
        check("rst_w2", 32'(bus_a.mac_w2), 32'd0);
        check("rst_b", 32'(bus_a.mac_b), 32'd0);

        // neuron 0: 4.0*0.25 + 4.0*0.25 = 2.0
        cfg_write(4'd0, 16'h0040);
        cfg_write(4'd1, 16'h0040);
        cfg_write(4'd2, 16'h0000);
        send_pair(16'h0400, 16'h0400, {16'h0200, 16'h0000, 16'h0000, 16'h0000},
                                      {16'h0200, 16'h0000, 16'h0000, 16'h0000});
        wait_idle();
        check("in_ready_after_stream", 32'(bus_a.in_ready), 32'd1);

        // neuron 1: 1.0*0.5 + 1.0*0.5 + 1.0 = 2.0; neuron 0 gives 0.5
        cfg_write(4'd3, 16'h0080);
        cfg_write(4'd4, 16'h0080);
        cfg_write(4'd5, 16'h0100);
        send_pair(16'h0100, 16'h0100, {16'h0080, 16'h0200, 16'h0000, 16'h0000},
                                      {16'h0080, 16'h0200, 16'h0000, 16'h0000});
        wait_idle();

        // bias -2.0 makes neuron 1 = -1.0: clamped vs passed through
        cfg_write(4'd5, 16'hFE00);
        send_pair(16'h0100, 16'h0100, {16'h0080, 16'h0000, 16'h0000, 16'h0000},
                                      {16'h0080, 16'hFF00, 16'h0000, 16'h0000});
        wait_idle();

        // back-pressure on neuron 0 while a stray input beat is offered
        out_ready = 1'b0;
        send_pair(16'h0400, 16'h0400, {16'h0200, 16'h0200, 16'h0000, 16'h0000},
                                      {16'h0200, 16'h0200, 16'h0000, 16'h0000});
        in_valid = 1'b1; in_data = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("stall_x1", 32'(bus_a.mac_d1), 32'h0400);
        check("stall_x2", 32'(bus_a.mac_d2), 32'h0400);
        check("stall_idx", 32'(bus_a.out_idx), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // writes outside S_X1 and to out-of-range addresses must not stick
        out_ready = 1'b0;
        send_pair(16'h0100, 16'h0100, {16'h0080, 16'h0000, 16'h0000, 16'h0000},
                                      {16'h0080, 16'hFF00, 16'h0000, 16'h0000});
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h7FFF;
        check("cfg_ready_busy", 32'(bus_a.cfg_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 cfg_we = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        cfg_write(4'd12, 16'h1111);
        cfg_write(4'd15, 16'h2222);
        send_pair(16'h0100, 16'h0100, {16'h0080, 16'h0000, 16'h0000, 16'h0000},
                                      {16'h0080, 16'hFF00, 16'h0000, 16'h0000});
        wait_idle();

        // asynchronous reset while a result is pending
        out_ready = 1'b0;
        send_beats(16'h0400, 16'h0400);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid_relu", 32'(bus_a.out_valid), 32'd0);
        check("arst_out_valid_pass", 32'(bus_b.out_valid), 32'd0);
        check("arst_w1", 32'(bus_a.mac_w1), 32'd0);
        check("arst_w2", 32'(bus_a.mac_w2), 32'd0);
        check("arst_b", 32'(bus_b.mac_b), 32'd0);
        check("arst_x1", 32'(bus_a.mac_d1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 32'(bus_a.out_valid | bus_b.out_valid), 32'd0);
        end
        check("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lyr2_seq.md
Name: lyr2_seq

Overview:
- Sequencing/control stage directly upstream of the 2-input layer-2 MAC unit in the 3x3-image VAE datapath.
- Collects two layer-1 activations from a valid/ready stream and holds them as MAC operands.
- Steps through N_OUT output neurons, driving each neuron's stored weights and bias into the MAC and capturing the combinational result.
- Applies optional ReLU and emits one result per neuron on a valid/ready output stream; all data is 16-bit Q8.8 (0x0100 = 1.0).

Parameters:
- N_OUT, 4, number of layer-2 neurons sequenced per input pair (1..5).
- RELU_EN, 1, 1 = clamp negative MAC results to 0x0000; 0 = pass through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  activation beat valid.
- in_ready  out  1  high in S_X1/S_X2.
- in_data  in  16  activation, Q8.8; first beat = x1, second = x2.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  4  coefficient address = 3*j + k; k: 0=w1, 1=w2, 2=bias.
- cfg_data  in  16  coefficient value, Q8.8.
- cfg_ready  out  1  high only in S_X1.
- mac_d1, mac_d2  out  16 each  registered x1, x2 to MAC.
- mac_w1, mac_w2, mac_b  out  16 each  coefficients of neuron idx (combinational select of regs).
- mac_res  in  16  MAC result, combinational from the mac_* outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  16  activated result.
- out_idx  out  3  neuron index of out_data.

Behaviour:
- Reset (async assert, sync release): state=S_X1; idx=0; x1=x2=0; all weights/biases=0; out_valid=0; out_data=0; out_idx=0. Reset mid-operation abandons the pair and any pending output; no further out_valid until new input.
- States:
  - S_X1: in_valid&in_ready -> x1<=in_data, go S_X2.
  - S_X2: in_valid -> x2<=in_data, idx<=0, go S_MAC.
  - S_MAC: one cycle; mac_* stable for the whole cycle. At cycle end: out_data<=act(mac_res), out_idx<=idx, out_valid<=1, go S_OUT.
  - S_OUT: hold out_valid/out_data/out_idx stable until out_ready. On out_valid&out_ready: out_valid<=0; if idx==N_OUT-1, idx<=0 and go S_X1; else idx<=idx+1 and go S_MAC.
- act(r): RELU_EN=1 and r[15]=1 -> 0x0000; otherwise r. No saturation here; the MAC defines wraparound.
- Latency: 1 cycle from x2 accept to first out_valid. Each further neuron is 1 cycle after the previous handshake. Max throughput 1 result per 2 cycles.
- in_ready=0 in S_MAC/S_OUT. x1/x2 never change until all N_OUT results are accepted.
- Config writes take effect only when cfg_we&cfg_ready, i.e. in S_X1.
  - The write is visible on the next clock.
  - cfg_addr >= 3*N_OUT is ignored with no state change.
  - cfg_we outside S_X1 is dropped; the master must wait for cfg_ready.
- Simultaneous cfg_we and in_valid in S_X1: both accepted in the same cycle.
- mac_d1/mac_d2 always reflect the x1/x2 registers. mac_w1/mac_w2/mac_b always reflect neuron idx, including when idle (idx=0).
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, cfg_ready=1, mac_w1=mac_w2=mac_b=0x0000.
- Load n0: w1=w2=0x0040, b=0x0000; x1=x2=0x0400; out_ready=1 -> out_data=0x0200, out_idx=0 one cycle after x2. Then neurons 1..3 (zero coefficients) give 0x0000, idx 1,2,3. in_ready returns to 1 after idx 3.
- n1: w1=w2=0x0080, b=0x0100; x1=x2=0x0100 -> idx 1 result 0x0200. With n1 b=0xFE00 -> 0x0000 under RELU_EN=1, 0xFF00 under RELU_EN=0.
- out_ready low 5 cycles on idx 0 -> out_data/out_idx stable, in_valid ignored, x regs unchanged. Stream resumes on out_ready.
- cfg_we in S_OUT and cfg_addr=12 in S_X1 -> coefficients unchanged (next pair reproduces prior results).
- rst_n low during S_OUT -> out_valid drops immediately; all coefficients read 0x0000 afterwards.
